// File: rtl/spi_responder_pkg.sv
// Shared constants for the SPI responder peripheral on the j1 IO bus.
package spi_responder_pkg;

    // Frame width and the byte sent when the CPU has nothing queued
    localparam int          SPI_DATA_W    = 8;
    localparam logic [7:0]  SPI_IDLE_FILL = 8'hFF;

    // Responder state: IDLE while ss_n is high, ACTIVE while selected
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // IO map: existing ports plus the two new SPI responder registers
    localparam logic [15:0] IO_PORTA_IN  = 16'h0001;
    localparam logic [15:0] IO_PORTA_OUT = 16'h0002;
    localparam logic [15:0] IO_PORTA_DIR = 16'h0004;
    localparam logic [15:0] IO_SPI_DATA  = 16'h0010;  // rd: rx_data, wr: tx holding reg
    localparam logic [15:0] IO_SPI_STAT  = 16'h0020;  // {overrun, active, tx_full, rx_valid}
    localparam logic [15:0] IO_UART_DATA = 16'h1000;
    localparam logic [15:0] IO_UART_STAT = 16'h2000;

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchroniser plus a third flop for edge detection on one
// asynchronous SPI pin.
module spi_resp_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetq,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            sync <= {3{RESET_VAL}};
        else
            sync <= {sync[1:0], d};
    end

    assign level = sync[1];
    assign rise  =  sync[1] & ~sync[2];
    assign fall  = ~sync[1] &  sync[2];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: an external master clocks bytes in on MOSI while
// the CPU-supplied holding byte (or the idle fill) is shifted out on MISO.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                DATA_W    = SPI_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_FILL = SPI_IDLE_FILL
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              wr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_full,
    output logic              active,
    output logic              overrun
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_lvl,  sck_rise,  sck_fall;
    logic ss_lvl,   ss_rise,   ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    // ss_n idles high so a reset never looks like a select
    spi_resp_sync #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetq(resetq), .d(spi_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_resp_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .resetq(resetq), .d(spi_ss_n),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );
    spi_resp_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetq(resetq), .d(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_rx;
    logic [DATA_W-1:0] shift_tx;
    logic [DATA_W-1:0] tx_hold;
    logic [DATA_W-1:0] rx_byte;
    logic [DATA_W-1:0] load_val;

    // Byte being completed by the current SCK rise, and next byte to send
    assign rx_byte  = {shift_rx[DATA_W-2:0], mosi_lvl};
    assign load_val = tx_full ? tx_hold : IDLE_FILL;

    assign spi_miso = shift_tx[DATA_W-1];
    assign active   = ~ss_lvl;

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall, shift_rx[DATA_W-1]};

    // Responder FSM: select handling, bit shifting and the CPU-side registers.
    // rd is applied first so a coincident byte completion wins; wr is applied
    // last so a coincident shifter load takes the old holding value.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_rx    <= '0;
            shift_tx    <= IDLE_FILL;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            if (rd) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state       <= ST_ACTIVE;
                        bit_cnt     <= '0;
                        shift_tx    <= load_val;
                        tx_full     <= 1'b0;
                        spi_miso_oe <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        // partial byte is dropped; received data is kept
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        spi_miso_oe <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            shift_rx <= rx_byte;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= rx_byte;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rd)
                                    overrun <= 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sck_fall) begin
                            if (bit_cnt == '0) begin
                                shift_tx <= load_val;
                                tx_full  <= 1'b0;
                            end else begin
                                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (wr) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a mode-0 master driven at clk/8, a transaction
// level model of the holding register / receive flags, and a monitor that
// compares DUT outputs against the expectation queues.
module tb_spi_responder;
    import spi_responder_pkg::*;

    logic       clk = 1'b0, resetq = 1'b0;
    logic       spi_sck = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       spi_miso, spi_miso_oe, rx_valid, tx_full, active, overrun;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_responder dut (
        .clk(clk), .resetq(resetq),
        .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr(wr), .tx_data(tx_data), .rd(rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_full(tx_full),
        .active(active), .overrun(overrun)
    );

    int n_chk = 0, n_fail = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit         m_pending  = 1'b0;
    logic [7:0] m_hold     = 8'h00;
    bit         m_rx_valid = 1'b0;
    bit         m_overrun  = 1'b0;
    logic [7:0] m_rx_data  = 8'h00;
    logic [7:0] rx_exp[$], miso_exp[$], miso_got[$];

    function automatic logic [7:0] m_load();
        if (m_pending) begin
            m_pending = 1'b0;
            return m_hold;
        end
        return 8'hFF;
    endfunction

    function automatic void m_write(logic [7:0] v);
        m_hold    = v;
        m_pending = 1'b1;
    endfunction

    function automatic void rx_complete(logic [7:0] b, bit rd_here);
        if (!m_rx_valid) rx_exp.push_back(b);
        if (rd_here)         m_overrun = 1'b0;
        else if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = b;
    endfunction

    // ---------------- monitor ----------------
    bit rxv_q = 1'b0;
    always @(negedge clk) begin
        if (resetq) begin
            if (rx_valid && !rxv_q) begin
                if (rx_exp.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    chk("rx_data_mon", 32'(rx_data), 32'(rx_exp.pop_front()));
                end
            end
            rxv_q = rx_valid;
            while (miso_got.size() > 0) begin
                if (miso_exp.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL miso_unexpected: got %0h expected none", miso_got.pop_front());
                end else begin
                    chk("miso_byte", 32'(miso_got.pop_front()), 32'(miso_exp.pop_front()));
                end
            end
        end
    end

    // ---------------- master stimulus ----------------
    logic [7:0] fb[$];
    int         partial = 0;
    bit         trail   = 1'b1;
    int         inj_rd = -1, inj_mid = -1, inj_bnd = -1;
    logic [7:0] mid_val = 8'h00, bnd_val = 8'h00;

    // wait n falling clk edges; optional wr/rd pulse lands on the third
    // rising edge after the SCK change, the cycle the DUT acts on it
    task automatic wait_n(input int n, input bit do_wr, input logic [7:0] v, input bit do_rd);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (do_wr) begin wr = 1'b1; tx_data = v; end
                if (do_rd) rd = 1'b1;
            end
            if (j == 2) begin wr = 1'b0; rd = 1'b0; end
        end
    endtask

    task automatic do_wr(input logic [7:0] v);
        @(negedge clk); wr = 1'b1; tx_data = v;
        @(negedge clk); wr = 1'b0;
        m_write(v);
    endtask

    task automatic do_rd();
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
    endtask

    task automatic check_state(string tag);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(m_rx_valid));
        chk({tag, "_rx_data"},  32'(rx_data),  32'(m_rx_data));
        chk({tag, "_overrun"},  32'(overrun),  32'(m_overrun));
        chk({tag, "_tx_full"},  32'(tx_full),  32'(m_pending));
    endtask

    task automatic do_frame();
        logic [7:0] loads[$];
        logic [7:0] cap;
        int  rises = 0;
        bit  stop  = 1'b0;
        bit  bnd;
        @(negedge clk);
        spi_ss_n = 1'b0;
        loads.push_back(m_load());
        wait_n(8, 1'b0, 8'h00, 1'b0);
        chk("miso_oe_sel", 32'(spi_miso_oe), 32'd1);
        chk("active_sel",  32'(active),      32'd1);
        chk("tx_full_sel", 32'(tx_full),     32'(m_pending));
        for (int k = 0; k < fb.size() && !stop; k++) begin
            cap = 8'h00;
            for (int i = 7; i >= 0 && !stop; i--) begin
                bnd = (k > 0 && i == 7);
                if (!(k == 0 && i == 7)) spi_sck = 1'b0;
                if (bnd) loads.push_back(m_load());
                spi_mosi = fb[k][i];
                wait_n(4, (bnd && inj_bnd == k) || (i == 4 && inj_mid == k),
                       bnd ? bnd_val : mid_val, 1'b0);
                if (bnd && inj_bnd == k) m_write(bnd_val);
                if (i == 4 && inj_mid == k) m_write(mid_val);
                spi_sck = 1'b1;
                cap[i]  = spi_miso;
                rises++;
                if (i == 0) rx_complete(fb[k], inj_rd == k);
                wait_n(4, 1'b0, 8'h00, i == 0 && inj_rd == k);
                if (i == 0) begin
                    miso_got.push_back(cap);
                    miso_exp.push_back(loads[k]);
                end
                if (partial > 0 && rises == partial) stop = 1'b1;
            end
        end
        if (trail || stop) begin
            spi_sck = 1'b0;
            if (!stop) void'(m_load());
            wait_n(4, 1'b0, 8'h00, 1'b0);
        end
        spi_ss_n = 1'b1;
        wait_n(8, 1'b0, 8'h00, 1'b0);
        if (spi_sck) begin
            spi_sck = 1'b0;
            wait_n(4, 1'b0, 8'h00, 1'b0);
        end
        chk("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
        chk("active_idle",  32'(active),      32'd0);
        partial = 0; trail = 1'b1; inj_rd = -1; inj_mid = -1; inj_bnd = -1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_miso",    32'(spi_miso),    32'd1);
        chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data),     32'd0);
        chk("rst_active",  32'(active),      32'd0);
        check_state("rst");

        // SCK toggling while deselected changes nothing
        for (int t = 0; t < 6; t++) begin
            spi_sck  = ~spi_sck;
            spi_mosi = ~spi_mosi;
            wait_n(4, 1'b0, 8'h00, 1'b0);
        end
        chk("idle_miso",    32'(spi_miso),    32'd1);
        chk("idle_miso_oe", 32'(spi_miso_oe), 32'd0);
        chk("idle_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check_state("idle");

        // queued byte goes out while a byte comes in
        do_wr(8'hA5);
        chk("t2_tx_full_pre", 32'(tx_full), 32'd1);
        fb = '{8'h3C};
        do_frame();
        check_state("t2");
        do_rd();

        // underrun sends the idle fill
        fb = '{8'h81};
        do_frame();
        check_state("t3");
        do_rd();

        // second byte without a read overruns; read clears both flags
        fb = '{8'h11, 8'h22};
        do_frame();
        chk("t4_overrun", 32'(overrun), 32'd1);
        check_state("t4");
        do_rd();
        check_state("t4_rd");

        // aborted frame is discarded, next frame is clean
        fb = '{8'hF0}; partial = 5;
        do_frame();
        chk("t5_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check_state("t5");
        fb = '{8'h0F};
        do_frame();
        check_state("t5b");
        do_rd();

        // read coincident with completion keeps the new byte, no overrun
        fb = '{8'h44};
        do_frame();
        fb = '{8'h55}; inj_rd = 0;
        do_frame();
        chk("t6_overrun", 32'(overrun), 32'd0);
        check_state("t6");
        do_rd();

        // write coincident with the boundary reload: old byte out, new held
        fb = '{8'h12, 8'h34}; trail = 1'b0;
        inj_mid = 0; mid_val = 8'h66;
        inj_bnd = 1; bnd_val = 8'h77;
        do_frame();
        chk("t6b_tx_full", 32'(tx_full), 32'd1);
        check_state("t6b");
        do_rd();
        fb = '{8'h9A};
        do_frame();
        check_state("t6c");
        do_rd();

        // randomized traffic
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 1) do_wr(8'($urandom));
            fb = '{};
            for (int b = 0; b < int'($urandom_range(1, 2)); b++)
                fb.push_back(8'($urandom));
            do_frame();
            check_state("rand");
            do_rd();
        end

        wait_n(10, 1'b0, 8'h00, 1'b0);
        chk("rx_exp_drained",   32'(rx_exp.size()),   32'd0);
        chk("miso_exp_drained", 32'(miso_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
